rom_bus: RTL and testbench

ROM_BUS -- requirements
Module: rom_bus

---
 rtl/rom_bus_if.sv | 24 ++
 rtl/rom_bus.sv | 135 +++++++++++++
 tb/tb_rom_bus.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/rom_bus_if.sv
// Host-side command/status bundle of rom_bus: strobes and write data in, read data and status out.
interface rom_bus_if #(
  parameter int DW = 8
) ();
  logic          wr_addr;
  logic          wr_data;
  logic          rd_data;
  logic          clr_err;
  logic [DW-1:0] wr_buffer;
  logic [DW-1:0] rd_buffer;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output wr_addr, wr_data, rd_data, clr_err, wr_buffer,
    input  rd_buffer, busy, done, err
  );

  modport slave (
    input  wr_addr, wr_data, rd_data, clr_err, wr_buffer,
    output rd_buffer, busy, done, err
  );
endinterface

// File: rtl/rom_bus.sv
// Parallel ROM/flash bus master: byte-wise address load, then fixed-timing
// setup/strobe/hold read or write cycles with tri-state address and data pins.
module rom_bus #(
  parameter int AW        = 19,
  parameter int DW        = 8,
  parameter int TSU       = 1,
  parameter int TPW       = 4,
  parameter int THD       = 1,
  parameter int ADDR_PARK = 1
) (
  input  logic          clk,
  input  logic          rst,
  rom_bus_if.slave      host,
  output wire  [AW-1:0] rom_a,
  inout  wire  [DW-1:0] rom_d,
  output logic          rom_cs_n,
  output logic          rom_oe_n,
  output logic          rom_we_n
);
  localparam int NB   = (AW + 7) / 8;
  localparam int EW   = NB * 8;
  localparam int PW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int MT1  = (TSU > TPW) ? TSU : TPW;
  localparam int MAXT = (MT1 > THD) ? MT1 : THD;
  localparam int CW   = $clog2(MAXT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_PULSE = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d, naddr_q, naddr_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [DW-1:0] wdat_q, wdat_d, rdbuf_q, rdbuf_d;
  logic          wr_q, wr_d, err_q, err_d, done_q, done_d, park_q;
  logic [EW-1:0] na_ext;
  logic [1:0]    nstb;
  logic          busy, one, start, viol;

  always_comb begin
    nstb    = {1'b0, host.wr_addr} + {1'b0, host.wr_data} + {1'b0, host.rd_data};
    one     = (nstb == 2'd1);
    busy    = (state_q != S_IDLE);
    start   = one && !host.wr_addr && !busy;
    viol    = (nstb > 2'd1) || (one && !host.wr_addr && busy);
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    naddr_d = naddr_q;
    ph_d    = ph_q;
    wdat_d  = wdat_q;
    rdbuf_d = rdbuf_q;
    wr_d    = wr_q;
    done_d  = 1'b0;
    na_ext  = EW'(naddr_q);
    err_d   = viol ? 1'b1 : (host.clr_err ? 1'b0 : err_q);

    // Address bytes land LSB first; bits beyond AW fall off in the truncation.
    if (one && host.wr_addr) begin
      na_ext[{ph_q, 3'b000} +: 8] = host.wr_buffer[7:0];
      naddr_d = na_ext[AW-1:0];
      ph_d    = (ph_q == PW'(NB - 1)) ? '0 : ph_q + 1'b1;
    end

    case (state_q)
      S_SETUP: if (cnt_q == CW'(TSU - 1)) begin
        state_d = S_PULSE;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      S_PULSE: if (cnt_q == CW'(TPW - 1)) begin
        state_d = S_HOLD;
        cnt_d   = '0;
        if (!wr_q) rdbuf_d = rom_d;
      end else cnt_d = cnt_q + 1'b1;
      S_HOLD: if (cnt_q == CW'(THD - 1)) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      default: ;
    endcase

    if (start) begin
      state_d = S_SETUP;
      cnt_d   = '0;
      addr_d  = naddr_q;
      naddr_d = naddr_q + 1'b1;
      ph_d    = '0;
      wr_d    = host.wr_data;
      if (host.wr_data) wdat_d = host.wr_buffer;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      naddr_q <= '0;
      ph_q    <= '0;
      wdat_q  <= '0;
      rdbuf_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      park_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      naddr_q <= naddr_d;
      ph_q    <= ph_d;
      wdat_q  <= wdat_d;
      rdbuf_q <= rdbuf_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      done_q  <= done_d;
      park_q  <= 1'b1;
    end
  end

  // Strobes and drivers decode straight from state so reset releases the pins at once.
  assign rom_cs_n = !busy;
  assign rom_oe_n = !((state_q == S_PULSE) && !wr_q);
  assign rom_we_n = !((state_q == S_PULSE) && wr_q);
  assign rom_d    = (busy && wr_q) ? wdat_q : 'z;
  assign rom_a    = (busy || ((ADDR_PARK != 0) && park_q)) ? addr_q : 'z;

  assign host.busy      = busy;
  assign host.done      = done_q;
  assign host.err       = err_q;
  assign host.rd_buffer = rdbuf_q;
endmodule

// File: tb/tb_rom_bus.sv
// Directed bench for rom_bus: cycle-level reference model plus literal spot checks.
module tb_rom_bus;
  localparam int AW  = 19;
  localparam int DW  = 8;
  localparam int TSU = 1;
  localparam int TPW = 4;
  localparam int THD = 1;
  localparam int T   = TSU + TPW + THD;
  localparam logic [31:0] MASK = (32'd1 << AW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic tb_den;
  logic [DW-1:0] tb_dval;
  wire  [AW-1:0] rom_a, rom_a2;
  wire  [DW-1:0] rom_d, rom_d2;
  logic rom_cs_n, rom_oe_n, rom_we_n, cs2, oe2, we2;
  int n_chk = 0, n_pass = 0;

  rom_bus_if #(.DW(DW)) hb ();
  rom_bus_if #(.DW(DW)) hb2 ();

  assign hb2.wr_addr   = hb.wr_addr;
  assign hb2.wr_data   = hb.wr_data;
  assign hb2.rd_data   = hb.rd_data;
  assign hb2.clr_err   = hb.clr_err;
  assign hb2.wr_buffer = hb.wr_buffer;

  // Undriven pins float high so released buses read as all ones.
  pullup (rom_a);
  pullup (rom_a2);
  pullup (rom_d);
  pullup (rom_d2);
  assign rom_d  = tb_den ? tb_dval : 'z;
  assign rom_d2 = tb_den ? tb_dval : 'z;

  rom_bus #(.AW(AW), .DW(DW), .TSU(TSU), .TPW(TPW), .THD(THD), .ADDR_PARK(1)) u_dut (
    .clk(clk), .rst(rst), .host(hb.slave), .rom_a(rom_a), .rom_d(rom_d),
    .rom_cs_n(rom_cs_n), .rom_oe_n(rom_oe_n), .rom_we_n(rom_we_n));

  rom_bus #(.AW(AW), .DW(DW), .TSU(TSU), .TPW(TPW), .THD(THD), .ADDR_PARK(0)) u_np (
    .clk(clk), .rst(rst), .host(hb2.slave), .rom_a(rom_a2), .rom_d(rom_d2),
    .rom_cs_n(cs2), .rom_oe_n(oe2), .rom_we_n(we2));

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
  endtask

  // Model: a cycle is (start edge, kind, address, data); outputs follow from offsets.
  int          ecnt = 0, e0 = -1000;
  logic        m_act = 0, m_wr = 0, m_err = 0, m_park = 0;
  logic [31:0] m_nxt = 0, m_cur = 0;
  int          m_ph = 0;
  logic [7:0]  m_wdat = 0, m_rdbuf = 0;

  always @(posedge clk) begin
    int n;
    logic bpre;
    ecnt++;
    if (rst) begin
      m_act = 0; m_wr = 0; m_err = 0; m_park = 0;
      m_nxt = 0; m_cur = 0; m_ph = 0; m_rdbuf = 0; e0 = -1000;
    end else begin
      if (m_act && !m_wr && (ecnt - e0 == TSU + TPW))
        m_rdbuf = tb_den ? tb_dval : 8'hFF;
      bpre = m_act && ((ecnt - 1 - e0) < T);
      n = int'(hb.wr_addr) + int'(hb.wr_data) + int'(hb.rd_data);
      if (n > 1 || (n == 1 && !hb.wr_addr && bpre)) m_err = 1;
      else if (hb.clr_err) m_err = 0;
      if (n == 1 && hb.wr_addr) begin
        m_nxt = ((m_nxt & ~(32'hFF << (8 * m_ph))) | (32'(hb.wr_buffer) << (8 * m_ph))) & MASK;
        m_ph  = (m_ph + 1) % ((AW + 7) / 8);
      end
      if (n == 1 && !hb.wr_addr && !bpre) begin
        m_act = 1; e0 = ecnt; m_wr = hb.wr_data; m_cur = m_nxt;
        if (hb.wr_data) m_wdat = hb.wr_buffer;
        m_nxt = (m_nxt + 1) & MASK; m_ph = 0;
      end
      m_park = 1;
    end
  end

  always @(negedge clk) begin
    int off;
    logic bsy, pul;
    off = ecnt - e0;
    bsy = m_act && off < T;
    pul = bsy && off >= TSU && off < TSU + TPW;
    chk("busy", hb.busy, bsy);
    chk("done", hb.done, m_act && off == T);
    chk("err", hb.err, m_err);
    chk("rd_buffer", hb.rd_buffer, m_rdbuf);
    chk("cs_n", rom_cs_n, !bsy);
    chk("oe_n", rom_oe_n, !(pul && !m_wr));
    chk("we_n", rom_we_n, !(pul && m_wr));
    chk("rom_a", rom_a, (bsy || m_park) ? m_cur : MASK);
    chk("rom_d", rom_d, (bsy && m_wr) ? m_wdat : (tb_den ? tb_dval : 8'hFF));
    chk("nopark_rom_a", rom_a2, bsy ? m_cur : MASK);
    chk("nopark_busy", hb2.busy, bsy);
  end

  task automatic nedge();
    @(negedge clk); #1;
  endtask

  task automatic load(input logic [7:0] b);
    hb.wr_buffer = b; hb.wr_addr = 1; nedge(); hb.wr_addr = 0;
  endtask

  task automatic do_read(input logic [7:0] v, input logic [31:0] a);
    hb.rd_data = 1; nedge(); hb.rd_data = 0;
    chk("rd_addr", rom_a, a);
    chk("rd_d_released", rom_d, 8'hFF);
    repeat (TSU) nedge();
    chk("rd_oe_low", rom_oe_n, 0);
    tb_den = 1; tb_dval = v;
    repeat (TPW) nedge();
    tb_den = 0;
    chk("rd_capture", hb.rd_buffer, v);
    repeat (THD) nedge();
    chk("rd_done", hb.done, 1);
  endtask

  task automatic do_write(input logic [7:0] v, input logic [31:0] a);
    hb.wr_buffer = v; hb.wr_data = 1; nedge(); hb.wr_data = 0;
    chk("wr_addr", rom_a, a);
    chk("wr_d_setup", rom_d, v);
    repeat (TSU) nedge();
    chk("wr_we_low", rom_we_n, 0);
    chk("wr_oe_high", rom_oe_n, 1);
    repeat (TPW) nedge();
    chk("wr_d_hold", rom_d, v);
    chk("wr_we_high", rom_we_n, 1);
    repeat (THD) nedge();
    chk("wr_done", hb.done, 1);
    chk("wr_d_released", rom_d, 8'hFF);
  endtask

  initial begin
    rst = 1; tb_den = 0; tb_dval = 0;
    hb.wr_addr = 0; hb.wr_data = 0; hb.rd_data = 0; hb.clr_err = 0; hb.wr_buffer = 0;
    repeat (3) nedge();
    chk("rst_busy", hb.busy, 0);
    chk("rst_cs_n", rom_cs_n, 1);
    chk("rst_rom_a_z", rom_a, 32'h7FFFF);
    rst = 0;
    nedge();
    chk("park_after_rst", rom_a, 0);
    chk("nopark_idle_z", rom_a2, 32'h7FFFF);

    load(8'h56); load(8'h34); load(8'h07);
    do_read(8'hA5, 32'h73456);
    do_read(8'h5A, 32'h73457);
    do_write(8'h3C, 32'h73458);
    chk("park_last_addr", rom_a, 32'h73458);

    // Read issued again while busy: dropped, flagged, addresses untouched.
    hb.rd_data = 1; repeat (2) nedge(); hb.rd_data = 0;
    chk("busy_viol_err", hb.err, 1);
    repeat (T - 1) nedge();
    chk("busy_viol_done", hb.done, 1);
    chk("busy_viol_rdbuf", hb.rd_buffer, 8'hFF);
    hb.clr_err = 1; nedge(); hb.clr_err = 0;
    chk("clr_err", hb.err, 0);
    hb.wr_buffer = 8'h11; hb.wr_addr = 1; hb.wr_data = 1; nedge();
    hb.wr_addr = 0; hb.wr_data = 0;
    chk("multi_err", hb.err, 1);
    chk("multi_no_cycle", hb.busy, 0);
    hb.clr_err = 1; hb.rd_data = 1; hb.wr_data = 1; nedge();
    hb.rd_data = 0; hb.wr_data = 0;
    chk("set_wins", hb.err, 1);
    nedge();
    chk("clr_err2", hb.err, 0);
    hb.clr_err = 0;
    do_read(8'hC3, 32'h7345A);

    load(8'hFF); load(8'hFF); load(8'hFF);
    do_read(8'h11, 32'h7FFFF);
    do_read(8'h22, 32'h00000);

    // Abandon a write mid-pulse.
    hb.wr_buffer = 8'h99; hb.wr_data = 1; nedge(); hb.wr_data = 0;
    repeat (TSU + 1) nedge();
    chk("pre_rst_we", rom_we_n, 0);
    rst = 1; #1;
    chk("rst_we_n", rom_we_n, 1);
    chk("rst_cs_n_mid", rom_cs_n, 1);
    chk("rst_d_z", rom_d, 8'hFF);
    chk("rst_a_z", rom_a, 32'h7FFFF);
    chk("rst_busy_mid", hb.busy, 0);
    repeat (2) nedge();
    rst = 0;
    repeat (T) begin
      nedge();
      chk("no_done_after_rst", hb.done, 0);
    end
    do_read(8'h77, 32'h0);
    repeat (2) nedge();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
